// File: rtl/expr_eval_ctrl_if.sv
// Handshake bundle for expr_eval_ctrl: character input stream and result output.
// master = source/consumer side, slave = controller side.
interface expr_eval_ctrl_if #(
  parameter int W = 16
);
  logic [7:0]   in;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] result;
  logic         err;
  logic         res_valid;
  logic         res_ready;
  logic         busy;
  logic         ovf;

  modport master (
    output in, in_valid, res_ready,
    input  in_ready, result, err, res_valid, busy, ovf
  );

  modport slave (
    input  in, in_valid, res_ready,
    output in_ready, result, err, res_valid, busy, ovf
  );
endinterface

// File: rtl/expr_eval_ctrl.sv
// Sequencing controller for a single-digit infix expression evaluator
// (digit (op digit)* '=', ops '+' and '*', '*' binds tighter than '+').
// Products use a 4-cycle LSB-first shift-add; arithmetic wraps modulo 2^W.
// Optional overflow detection is enabled by defining EXPR_OVF_DETECT_EN;
// without it ovf is tied low and no detection logic exists.
module expr_eval_ctrl #(
  parameter int W = 16
) (
  input logic             clk,
  input logic             clr,
  expr_eval_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    OPND,
    OPER,
    MUL,
    SYNC,
    DONE
  } state_t;

  state_t       state, nxt;
  logic [W-1:0] sum, sum_n;
  logic [W-1:0] term, term_n;
  logic [W-1:0] mcand, mcand_n;
  logic [3:0]   mdig, mdig_n;
  logic [1:0]   cnt, cnt_n;
  logic         op_mul, op_mul_n;
  logic         err_r, err_n;
  logic [W-1:0] result_r, result_n;
  logic         in_ready_r, busy_r, res_valid_r;

  logic         is_dig, is_add, is_mul, is_eq;
  logic [W-1:0] dx;

`ifdef EXPR_OVF_DETECT_EN
  logic         ovf_r, ovf_n;
  logic [W:0]   add_st;
  logic [W:0]   add_pp;
  logic [W+2:0] shifted;
  logic         pp_lost;
`else
  logic [W-1:0] add_st;
  logic [W-1:0] add_pp;
  logic [W-1:0] shifted;
`endif

  // Character classification; the low nibble of '0'..'9' is the digit value.
  always_comb begin
    is_dig = (bus.in >= 8'h30) && (bus.in <= 8'h39);
    is_add = (bus.in == 8'h2B);
    is_mul = (bus.in == 8'h2A);
    is_eq  = (bus.in == 8'h3D);
    dx     = {{(W-4){1'b0}}, bus.in[3:0]};
  end

  // Adders: running sum + term, and shift-add partial product accumulation.
`ifdef EXPR_OVF_DETECT_EN
  always_comb begin
    add_st  = {1'b0, sum} + {1'b0, term};
    shifted = {3'b000, mcand} << cnt;
    pp_lost = |shifted[W+2:W];
    add_pp  = {1'b0, term} + {1'b0, shifted[W-1:0]};
  end
`else
  always_comb begin
    add_st  = sum + term;
    shifted = mcand << cnt;
    add_pp  = term + shifted;
  end
`endif

  // Next-state and next-register-value decode for every state.
  always_comb begin
    nxt      = state;
    sum_n    = sum;
    term_n   = term;
    mcand_n  = mcand;
    mdig_n   = mdig;
    cnt_n    = cnt;
    op_mul_n = op_mul;
    err_n    = err_r;
    result_n = result_r;
`ifdef EXPR_OVF_DETECT_EN
    ovf_n    = ovf_r;
`endif
    case (state)
      IDLE: if (bus.in_valid) begin
        if (is_dig) begin
          term_n = dx;
          sum_n  = '0;
          nxt    = OPND;
        end else if (is_eq) begin
          err_n    = 1'b1;
          result_n = '0;
          nxt      = DONE;
        end else begin
          nxt = SYNC;
        end
      end
      OPND: if (bus.in_valid) begin
        if (is_add) begin
          op_mul_n = 1'b0;
          nxt      = OPER;
        end else if (is_mul) begin
          op_mul_n = 1'b1;
          nxt      = OPER;
        end else if (is_eq) begin
          result_n = add_st[W-1:0];
`ifdef EXPR_OVF_DETECT_EN
          if (add_st[W]) ovf_n = 1'b1;
`endif
          nxt = DONE;
        end else begin
          nxt = SYNC;
        end
      end
      OPER: if (bus.in_valid) begin
        if (is_dig && !op_mul) begin
          sum_n  = add_st[W-1:0];
          term_n = dx;
`ifdef EXPR_OVF_DETECT_EN
          if (add_st[W]) ovf_n = 1'b1;
`endif
          nxt = OPND;
        end else if (is_dig) begin
          mcand_n = term;
          mdig_n  = bus.in[3:0];
          term_n  = '0;
          cnt_n   = '0;
          nxt     = MUL;
        end else if (is_eq) begin
          err_n    = 1'b1;
          result_n = '0;
          nxt      = DONE;
        end else begin
          nxt = SYNC;
        end
      end
      MUL: begin
        if (mdig[cnt]) begin
          term_n = add_pp[W-1:0];
`ifdef EXPR_OVF_DETECT_EN
          if (add_pp[W] || pp_lost) ovf_n = 1'b1;
`endif
        end
        cnt_n = cnt + 2'd1;
        if (cnt == 2'd3) nxt = OPND;
      end
      SYNC: if (bus.in_valid && is_eq) begin
        err_n    = 1'b1;
        result_n = '0;
        nxt      = DONE;
      end
      DONE: if (bus.res_ready) begin
        sum_n  = '0;
        term_n = '0;
        err_n  = 1'b0;
`ifdef EXPR_OVF_DETECT_EN
        ovf_n  = 1'b0;
`endif
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // State, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= IDLE;
      sum         <= '0;
      term        <= '0;
      mcand       <= '0;
      mdig        <= '0;
      cnt         <= '0;
      op_mul      <= 1'b0;
      err_r       <= 1'b0;
      result_r    <= '0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
`ifdef EXPR_OVF_DETECT_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      state       <= nxt;
      sum         <= sum_n;
      term        <= term_n;
      mcand       <= mcand_n;
      mdig        <= mdig_n;
      cnt         <= cnt_n;
      op_mul      <= op_mul_n;
      err_r       <= err_n;
      result_r    <= result_n;
      in_ready_r  <= (nxt == IDLE) || (nxt == OPND) || (nxt == OPER) || (nxt == SYNC);
      busy_r      <= (nxt != IDLE);
      res_valid_r <= (nxt == DONE);
`ifdef EXPR_OVF_DETECT_EN
      ovf_r       <= ovf_n;
`endif
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.busy      = busy_r;
  assign bus.res_valid = res_valid_r;
  assign bus.result    = result_r;
  assign bus.err       = err_r;
`ifdef EXPR_OVF_DETECT_EN
  assign bus.ovf       = res_valid_r & ovf_r;
`else
  assign bus.ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// Directed bench for expr_eval_ctrl: a W=16 instance plus a W=8 instance
// fed the same stream (used for the modulo/overflow expression).
module tb_expr_eval_ctrl;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   total  = 0;
  int   passed = 0;

`ifdef EXPR_OVF_DETECT_EN
  localparam logic OVF8_EXP = 1'b1;
`else
  localparam logic OVF8_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  expr_eval_ctrl_if #(.W(16)) b ();
  expr_eval_ctrl_if #(.W(8))  b8 ();

  assign b8.in        = b.in;
  assign b8.in_valid  = b.in_valid;
  assign b8.res_ready = b.res_ready;

  expr_eval_ctrl #(.W(16)) dut (
    .clk (clk),
    .clr (clr),
    .bus (b)
  );

  expr_eval_ctrl #(.W(8)) dut8 (
    .clk (clk),
    .clr (clr),
    .bus (b8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Present one character and wait (bounded) for its handshake edge.
  task automatic send(input logic [7:0] c, output int stall);
    stall      = 0;
    b.in       = c;
    b.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (b.in_ready) break;
      stall++;
      if (stall > 20) begin
        total++;
        $error("FAIL send_timeout: observed in_ready low %0d cycles expected handshake", stall);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Stream a string with in_valid held high; the character after a '*' operand
  // must stall exactly 4 cycles, all others none.
  task automatic send_str(input string s);
    int st;
    int exp_st;
    for (int i = 0; i < s.len(); i++) begin
      exp_st = 0;
      if (i >= 2)
        if (s[i-2] == "*" && s[i-1] >= "0" && s[i-1] <= "9") exp_st = 4;
      send(s[i], st);
      chk($sformatf("stall '%s'[%0d]", s, i), st, exp_st);
    end
    b.in_valid = 1'b0;
  endtask

  // Called one cycle after the '=' handshake.
  task automatic expect_res(input string tag, input logic [15:0] res, input logic e);
    chk({tag, ".res_valid"}, b.res_valid, 1);
    chk({tag, ".result"}, b.result, res);
    chk({tag, ".err"}, b.err, e);
    chk({tag, ".in_ready"}, b.in_ready, 0);
    chk({tag, ".ovf"}, b.ovf, 0);
  endtask

  task automatic finish_hs(input string tag);
    @(posedge clk);
    #1;
    chk({tag, ".idle_valid"}, b.res_valid, 0);
    chk({tag, ".idle_busy"}, b.busy, 0);
    chk({tag, ".idle_ready"}, b.in_ready, 1);
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, ".result"}, b.result, 0);
    chk({tag, ".err"}, b.err, 0);
    chk({tag, ".res_valid"}, b.res_valid, 0);
    chk({tag, ".busy"}, b.busy, 0);
    chk({tag, ".ovf"}, b.ovf, 0);
    chk({tag, ".in_ready"}, b.in_ready, 1);
  endtask

  initial begin
    int st;
    b.in        = 8'h00;
    b.in_valid  = 1'b0;
    b.res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_outputs("reset");
    chk("reset.result8", b8.result, 0);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;

    send_str("3+4*5=");
    expect_res("3+4*5", 16'd23, 1'b0);
    chk("3+4*5.busy", b.busy, 1);
    finish_hs("3+4*5");

    send_str("2*3*4=");
    expect_res("2*3*4", 16'd24, 1'b0);
    finish_hs("2*3*4");

    send_str("9+9+9=");
    expect_res("9+9+9", 16'd27, 1'b0);
    finish_hs("9+9+9");

    send_str("1+=");
    expect_res("1+=", 16'd0, 1'b1);
    finish_hs("1+=");

    send_str("12+3=");
    expect_res("12+3", 16'd0, 1'b1);
    finish_hs("12+3");

    // Consumer back-pressure: result must hold while res_ready is low.
    b.res_ready = 1'b0;
    send_str("7=");
    expect_res("7=", 16'd7, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold7[%0d].res_valid", k), b.res_valid, 1);
      chk($sformatf("hold7[%0d].result", k), b.result, 7);
      chk($sformatf("hold7[%0d].in_ready", k), b.in_ready, 0);
    end
    b.res_ready = 1'b1;
    finish_hs("7=");

    b.res_ready = 1'b0;
    send_str("x5=");
    expect_res("x5=", 16'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("holdx[%0d].err", k), b.err, 1);
      chk($sformatf("holdx[%0d].res_valid", k), b.res_valid, 1);
    end
    b.res_ready = 1'b1;
    finish_hs("x5=");

    send_str("4=");
    expect_res("4=", 16'd4, 1'b0);
    finish_hs("4=");

    // Asynchronous reset in the middle of the multiply sequence.
    send_str("6*");
    send(8'h37, st);
    chk("6*7.stall", st, 0);
    chk("6*7.in_mul", b.in_ready, 0);
    b.in_valid = 1'b0;
    #2;
    clr = 1'b1;
    #1;
    reset_outputs("midmul");
    @(negedge clk);
    reset_outputs("midmul_held");
    clr = 1'b0;
    @(posedge clk);
    #1;
    send_str("8=");
    expect_res("8=", 16'd8, 1'b0);
    finish_hs("8=");

    send_str("9*9*9=");
    expect_res("9*9*9", 16'd729, 1'b0);
    chk("9*9*9.w8.res_valid", b8.res_valid, 1);
    chk("9*9*9.w8.result", b8.result, 217);
    chk("9*9*9.w8.err", b8.err, 0);
    chk("9*9*9.w8.ovf", b8.ovf, OVF8_EXP);
    finish_hs("9*9*9");
    chk("9*9*9.w8.ovf_cleared", b8.ovf, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
